// File: rtl/poly_mult_tile_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package  : poly_mult_pkg
// Brief    : Scheduler state encoding and tile-geometry helpers shared by the
//            tile scheduler and the polynomial output loader.
// Revision : 1.0
// ============================================================================
package poly_mult_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_MEM  = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_MULT = 3'd4,
        S_DONE      = 3'd5
    } sched_state_e;

    function automatic int num_tiles(input int width, input int tile_width);
        return width / tile_width;
    endfunction

    // Index width for a count, never narrower than one bit.
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage : poly_mult_pkg
`default_nettype wire

// File: rtl/poly_mult_tile_scheduler_tile_index_counter.sv
`default_nettype none
// ============================================================================
// Module   : tile_index_counter
// Brief    : 2-D (A outer, B inner) tile index counter with clear/advance and
//            a flag marking the final pair.
// Revision : 1.0
// ============================================================================
module tile_index_counter #(
    parameter int NUM_A = 16,
    parameter int NUM_B = 16,
    parameter int A_W   = 4,
    parameter int B_W   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_clear,
    input  logic           i_advance,
    output logic [A_W-1:0] o_a_idx,
    output logic [B_W-1:0] o_b_idx,
    output logic           o_last
);

    localparam logic [A_W-1:0] c_a_max = A_W'(NUM_A - 1);
    localparam logic [B_W-1:0] c_b_max = B_W'(NUM_B - 1);

    logic [A_W-1:0] r_a_idx;
    logic [B_W-1:0] r_b_idx;
    logic           w_a_last;
    logic           w_b_last;

    assign w_a_last = (r_a_idx == c_a_max);
    assign w_b_last = (r_b_idx == c_b_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_idx <= '0;
            r_b_idx <= '0;
        end else if (i_clear) begin
            r_a_idx <= '0;
            r_b_idx <= '0;
        end else if (i_advance) begin
            // B wraps into the next A row; A saturates on the final pair.
            if (w_b_last) begin
                r_b_idx <= '0;
                if (!w_a_last) begin
                    r_a_idx <= r_a_idx + A_W'(1);
                end
            end else begin
                r_b_idx <= r_b_idx + B_W'(1);
            end
        end
    end

    assign o_a_idx = r_a_idx;
    assign o_b_idx = r_b_idx;
    assign o_last  = w_a_last && w_b_last;

endmodule : tile_index_counter
`default_nettype wire

// File: rtl/poly_mult_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : poly_mult_tile_scheduler
// Brief    : Walks every (A-tile, B-tile) pair through poly_mult_top: buffer
//            read, read-latency wait, multiplier start, wait for completion.
// Revision : 1.0
// ============================================================================
module poly_mult_tile_scheduler
    import poly_mult_pkg::*;
#(
    parameter int POLY_A_WIDTH      = 128,
    parameter int POLY_B_WIDTH      = 128,
    parameter int POLY_A_TILE_WIDTH = 8,
    parameter int POLY_B_TILE_WIDTH = 8,
    parameter int MEM_LATENCY       = 1,
    localparam int NUM_A_TILES = num_tiles(POLY_A_WIDTH, POLY_A_TILE_WIDTH),
    localparam int NUM_B_TILES = num_tiles(POLY_B_WIDTH, POLY_B_TILE_WIDTH),
    localparam int A_IDX_W     = idx_width(NUM_A_TILES),
    localparam int B_IDX_W     = idx_width(NUM_B_TILES),
    localparam int NUM_PAIRS   = NUM_A_TILES * NUM_B_TILES,
    localparam int PC_W        = idx_width(NUM_PAIRS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               sched_done,
    output logic [A_IDX_W-1:0] a_tile_addr,
    output logic [B_IDX_W-1:0] b_tile_addr,
    output logic               tile_rd_en,
    output logic               mult_start,
    input  logic               mult_done,
    output logic               last_pair,
    output logic [PC_W-1:0]    pair_count,
    output logic               protocol_err
);

    localparam int               LAT_W      = idx_width(MEM_LATENCY);
    localparam logic [LAT_W-1:0] c_lat_load = LAT_W'(MEM_LATENCY - 1);

    sched_state_e        r_state;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic                r_busy;
    logic                r_tile_rd_en;
    logic                r_mult_start;
    logic                r_sched_done;
    logic                r_protocol_err;
    logic [PC_W-1:0]     r_pair_count;

    logic                w_start_ok;
    logic                w_abort_run;
    logic                w_clear;
    logic                w_advance;
    logic                w_last;
    logic [A_IDX_W-1:0]  w_a_idx;
    logic [B_IDX_W-1:0]  w_b_idx;

    assign w_start_ok  = (r_state == S_IDLE) && start && !abort;
    assign w_abort_run = (r_state != S_IDLE) && abort;
    assign w_clear     = w_start_ok || w_abort_run;
    assign w_advance   = (r_state == S_WAIT_MULT) && mult_done && !abort;

    tile_index_counter #(
        .NUM_A (NUM_A_TILES),
        .NUM_B (NUM_B_TILES),
        .A_W   (A_IDX_W),
        .B_W   (B_IDX_W)
    ) u_tile_index_counter (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_a_idx   (w_a_idx),
        .o_b_idx   (w_b_idx),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_lat_cnt      <= '0;
            r_busy         <= 1'b0;
            r_tile_rd_en   <= 1'b0;
            r_mult_start   <= 1'b0;
            r_sched_done   <= 1'b0;
            r_protocol_err <= 1'b0;
            r_pair_count   <= '0;
        end else begin
            r_tile_rd_en <= 1'b0;
            r_mult_start <= 1'b0;
            r_sched_done <= 1'b0;

            if (mult_done && (r_state != S_WAIT_MULT)) begin
                r_protocol_err <= 1'b1;
            end

            if (w_abort_run) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_ok) begin
                            r_state      <= S_FETCH;
                            r_busy       <= 1'b1;
                            r_tile_rd_en <= 1'b1;
                            r_lat_cnt    <= c_lat_load;
                            r_pair_count <= '0;
                        end
                    end
                    // r_lat_cnt holds the remaining WAIT_MEM cycles.
                    S_FETCH, S_WAIT_MEM: begin
                        if (r_lat_cnt == '0) begin
                            r_state      <= S_ISSUE;
                            r_mult_start <= 1'b1;
                        end else begin
                            r_state   <= S_WAIT_MEM;
                            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                        end
                    end
                    S_ISSUE: begin
                        r_state <= S_WAIT_MULT;
                    end
                    S_WAIT_MULT: begin
                        if (mult_done) begin
                            r_pair_count <= r_pair_count + PC_W'(1);
                            if (w_last) begin
                                r_state      <= S_DONE;
                                r_busy       <= 1'b0;
                                r_sched_done <= 1'b1;
                            end else begin
                                r_state      <= S_FETCH;
                                r_tile_rd_en <= 1'b1;
                                r_lat_cnt    <= c_lat_load;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy         = r_busy;
    assign sched_done   = r_sched_done;
    assign a_tile_addr  = w_a_idx;
    assign b_tile_addr  = w_b_idx;
    assign tile_rd_en   = r_tile_rd_en;
    // An abort landing on the ISSUE cycle must not reach the multiplier.
    assign mult_start   = r_mult_start && !abort;
    assign last_pair    = r_busy && w_last;
    assign pair_count   = r_pair_count;
    assign protocol_err = r_protocol_err;

endmodule : poly_mult_tile_scheduler
`default_nettype wire

// File: tb/tb_poly_mult_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_mult_tile_scheduler
// Brief    : Scoreboard bench: default 16x16-tile instance plus a 2x3-tile,
//            MEM_LATENCY=3 instance.
// Revision : 1.0
// ============================================================================
module tb_poly_mult_tile_scheduler;

    typedef logic [31:0] word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort, tb_done, resp_done, resp_en, mult_done;
    logic       busy, sched_done, tile_rd_en, mult_start, last_pair, protocol_err;
    logic [3:0] a_addr, b_addr;
    logic [8:0] pair_count;

    logic       start3, abort3, resp3_done;
    logic       busy3, sched_done3, tile_rd_en3, mult_start3, last_pair3, protocol_err3;
    logic [0:0] a3_addr;
    logic [1:0] b3_addr;
    logic [2:0] pair_count3;

    assign mult_done = tb_done | resp_done;

    poly_mult_tile_scheduler u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
        .sched_done(sched_done), .a_tile_addr(a_addr), .b_tile_addr(b_addr),
        .tile_rd_en(tile_rd_en), .mult_start(mult_start), .mult_done(mult_done),
        .last_pair(last_pair), .pair_count(pair_count), .protocol_err(protocol_err)
    );

    poly_mult_tile_scheduler #(
        .POLY_A_WIDTH(16), .POLY_B_WIDTH(24), .POLY_A_TILE_WIDTH(8),
        .POLY_B_TILE_WIDTH(8), .MEM_LATENCY(3)
    ) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .busy(busy3),
        .sched_done(sched_done3), .a_tile_addr(a3_addr), .b_tile_addr(b3_addr),
        .tile_rd_en(tile_rd_en3), .mult_start(mult_start3), .mult_done(resp3_done),
        .last_pair(last_pair3), .pair_count(pair_count3), .protocol_err(protocol_err3)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    word_t exp_q[$];
    word_t exp3_q[$];
    int    n_rd = 0, n_done = 0, first_ms = -1;
    int    n_rd3 = 0, n_done3 = 0, first3 = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Expected {a, b, last_pair} for pair p of the 16x16 instance.
    function automatic word_t pair_word(input int p);
        return word_t'(((p / 16) << 5) | ((p % 16) << 1) | ((p == 255) ? 1 : 0));
    endfunction

    // Expected {a, b, last_pair} for pair p of the 2x3 instance.
    function automatic word_t pair_word3(input int p);
        return word_t'(((p / 3) << 3) | ((p % 3) << 1) | ((p == 5) ? 1 : 0));
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Multiplier models: answer three cycles after each mult_start.
    initial begin : resp_main
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && mult_start) begin
                repeat (2) @(negedge clk);
                resp_done = resp_en;
                @(negedge clk);
                resp_done = 1'b0;
            end
        end
    end

    initial begin : resp_three
        resp3_done = 1'b0;
        forever begin
            @(negedge clk);
            if (mult_start3) begin
                repeat (2) @(negedge clk);
                resp3_done = 1'b1;
                @(negedge clk);
                resp3_done = 1'b0;
            end
        end
    end

    // Monitors: pop the scoreboard on each mult_start, check strobe widths.
    initial begin : mon_main
        int rd_run;
        rd_run = 0;
        forever begin
            @(negedge clk);
            if (tile_rd_en) begin
                rd_run++;
                n_rd++;
            end else if (rd_run != 0) begin
                chk("rd_en_width", rd_run, 1);
                rd_run = 0;
            end
            if (sched_done) n_done++;
            if (mult_start) begin
                if (first_ms < 0) first_ms = cyc;
                if (exp_q.size() == 0) chk("pending_pairs", exp_q.size(), 1);
                else chk("pair_addr", {23'd0, a_addr, b_addr, last_pair}, exp_q.pop_front());
            end
        end
    end

    initial begin : mon_three
        int rd_run;
        rd_run = 0;
        forever begin
            @(negedge clk);
            if (tile_rd_en3) begin
                rd_run++;
                n_rd3++;
            end else if (rd_run != 0) begin
                chk("rd_en3_width", rd_run, 1);
                rd_run = 0;
            end
            if (sched_done3) n_done3++;
            if (mult_start3) begin
                if (first3 < 0) first3 = cyc;
                if (exp3_q.size() == 0) chk("pending_pairs3", exp3_q.size(), 1);
                else chk("pair3_addr", {28'd0, a3_addr, b3_addr, last_pair3}, exp3_q.pop_front());
            end
        end
    end

    task automatic wait_ms(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mult_start) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_mult_start_seen"}, seen, 1);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
    endtask

    task automatic run_full(input string tag, input logic perr_exp);
        int c0, d0;
        bit seen;
        for (int p = 0; p < 256; p++) exp_q.push_back(pair_word(p));
        d0 = n_done;
        first_ms = -1;
        seen = 1'b0;
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (sched_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_pair_count"}, pair_count, 256);
        @(negedge clk);
        chk({tag, "_done_pulses"}, n_done - d0, 1);
        chk({tag, "_queue_drained"}, exp_q.size(), 0);
        chk({tag, "_start_latency"}, first_ms - c0, 2);
        chk({tag, "_protocol_err"}, protocol_err, perr_exp);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        int d0, r0, c0;
        bit seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0; tb_done = 1'b0; resp_en = 1'b0;
        start3 = 1'b0; abort3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_sched_done", sched_done, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_b_addr", b_addr, 0);
        chk("rst_rd_en", tile_rd_en, 0);
        chk("rst_mult_start", mult_start, 0);
        chk("rst_last_pair", last_pair, 0);
        chk("rst_pair_count", pair_count, 0);
        chk("rst_protocol_err", protocol_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Spurious completion while idle.
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        @(negedge clk);
        chk("spurious_protocol_err", protocol_err, 1);
        chk("spurious_busy", busy, 0);

        // start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy, 0);

        resp_en = 1'b1;
        run_full("run1", 1'b1);
        resp_en = 1'b0;
        @(negedge clk);

        // Abort during WAIT_MULT of pair 5.
        for (int p = 0; p < 6; p++) exp_q.push_back(pair_word(p));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int p = 0; p < 5; p++) begin
            wait_ms("abort_run");
            pulse_done();
        end
        wait_ms("abort_pair5");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_pair_count", pair_count, 5);
        chk("abort_a_addr", a_addr, 0);
        chk("abort_b_addr", b_addr, 0);
        d0 = n_done;
        repeat (4) @(negedge clk);
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_queue", exp_q.size(), 0);
        chk("abort_protocol_err", protocol_err, 1);

        // Restart begins at (0,0); then async reset lands mid-ISSUE of pair 1.
        exp_q.push_back(pair_word(0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ms("restart");
        pulse_done();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mult_start", mult_start, 0);
        chk("arst_rd_en", tile_rd_en, 0);
        chk("arst_sched_done", sched_done, 0);
        chk("arst_last_pair", last_pair, 0);
        chk("arst_pair_count", pair_count, 0);
        chk("arst_a_addr", a_addr, 0);
        chk("arst_b_addr", b_addr, 0);
        chk("arst_protocol_err", protocol_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        resp_en = 1'b1;
        run_full("run2", 1'b0);

        // MEM_LATENCY=3 instance with a start pulse during WAIT_MEM.
        for (int p = 0; p < 6; p++) exp3_q.push_back(pair_word3(p));
        d0 = n_done3;
        r0 = n_rd3;
        first3 = -1;
        seen = 1'b0;
        start3 = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("ml3_busy_wait_mem", busy3, 1);
        chk("ml3_pair_count_wait_mem", pair_count3, 0);
        chk("ml3_a_wait_mem", a3_addr, 0);
        chk("ml3_b_wait_mem", b3_addr, 0);
        chk("ml3_rd_en_wait_mem", tile_rd_en3, 0);
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (sched_done3) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ml3_done_seen", seen, 1);
        chk("ml3_busy_at_done", busy3, 0);
        chk("ml3_pair_count", pair_count3, 6);
        @(negedge clk);
        chk("ml3_done_pulses", n_done3 - d0, 1);
        chk("ml3_rd_pulses", n_rd3 - r0, 6);
        chk("ml3_start_latency", first3 - c0, 4);
        chk("ml3_queue_drained", exp3_q.size(), 0);
        chk("ml3_protocol_err", protocol_err3, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_poly_mult_tile_scheduler
`default_nettype wire
